// File: rtl/frame_stream_if.sv
// Memory read bus and pixel stream between the frame source and its neighbours.
interface frame_stream_if;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic [15:0] sdata;
  logic        svalid;
  logic        sready;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    output sdata,
    output svalid,
    input  sready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    input  sdata,
    input  svalid,
    output sready
  );
endinterface

// File: rtl/frame_stream_src.sv
// Streams RGB565 frames from a frame buffer to a display sink through a small FIFO.
module frame_stream_src #(
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [31:0]    base_addr,
  output logic           frame_done,
  output logic           busy,
  frame_stream_if.master bus
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      frame_base;
  logic [CNT_W-1:0] pix_idx;
  logic [CNT_W-1:0] out_idx;
  logic             rd_vld_p1;
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [PTR_W:0]   occ_sum;
  logic             rd_en, pop, fifo_empty, to_idle;

  assign fifo_empty = (fifo_cnt == '0);
  // Reads in flight count against FIFO space so every returning word has a slot.
  assign occ_sum    = fifo_cnt + {{PTR_W{1'b0}}, rd_vld_p1};
  assign pop        = !fifo_empty && bus.sready;
  assign to_idle    = (state == DRAIN) && (state_nxt == IDLE);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        rd_en = (occ_sum < DEPTH_C);
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN:   if (!rd_vld_p1 && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: read request issue and pixel addressing
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_base <= '0;
      pix_idx    <= '0;
      out_idx    <= '0;
      rd_vld_p1  <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_en;
      if (state == IDLE && enable) begin
        frame_base <= base_addr;
        pix_idx    <= '0;
      end else if (to_idle) begin
        pix_idx <= '0;
      end else if (rd_en) begin
        if (pix_idx == LAST_PIX) begin
          pix_idx    <= '0;
          frame_base <= base_addr;
        end else begin
          pix_idx <= pix_idx + 1'b1;
        end
      end
      if (to_idle)  out_idx <= '0;
      else if (pop) out_idx <= (out_idx == LAST_PIX) ? '0 : out_idx + 1'b1;
    end
  end

  // Stage p1: returning read data lands in the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rd_vld_p1) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({rd_vld_p1, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1) fifo_mem[wr_ptr] <= bus.mem_rdata;
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = frame_base + (32'(pix_idx) << 1);
  assign bus.svalid    = !fifo_empty;
  assign bus.sdata     = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
  assign frame_done    = pop && (out_idx == LAST_PIX);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_frame_stream_src.sv
// Bench for frame_stream_src: a 16-pixel and a 64-pixel instance, a memory model and a scoreboard.
module tb_frame_stream_src;
  localparam int DEPTH = 4;
  localparam logic [31:0] A0 = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en   [2];
  logic [31:0] base [2];
  logic        rdy  [2];
  logic [31:0] addr_w [2];
  logic        rd_w [2], sv_w [2], fd_w [2], busy_w [2];
  logic [15:0] sd_w [2];

  function automatic logic [15:0] memf(logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  function automatic int fpix(int g);
    return (g == 0) ? 16 : 64;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    frame_stream_if bus();
    frame_stream_src #(.FRAME_PIXELS((g == 0) ? 16 : 64), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk        (clk),
      .reset      (rst),
      .enable     (en[g]),
      .base_addr  (base[g]),
      .frame_done (fd_w[g]),
      .busy       (busy_w[g]),
      .bus        (bus)
    );
    assign bus.sready = rdy[g];
    always @(posedge clk)
      bus.mem_rdata <= bus.mem_rd_en ? memf(bus.mem_addr) : 16'($urandom);
    assign addr_w[g] = bus.mem_addr;
    assign rd_w[g]   = bus.mem_rd_en;
    assign sv_w[g]   = bus.svalid;
    assign sd_w[g]   = bus.sdata;
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state, one slot per instance (0 = IDLE, 1 = RUN, 2 = DRAIN)
  int          st_m [2], idx_m [2], out_m [2], occ_m [2], infl_m [2];
  logic [31:0] base_m [2];
  logic [15:0] sbq [2][$];
  int          rd_cnt [2], hs_cnt [2], fd_cnt [2];
  logic        stall_m [2];
  logic [15:0] stall_sd [2];

  task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: actual %h required %h", name, g, $time, act, exp);
    end
  endtask

  task automatic model_reset(int g);
    st_m[g] = 0; idx_m[g] = 0; out_m[g] = 0; occ_m[g] = 0; infl_m[g] = 0;
    sbq[g].delete();
    stall_m[g] = 1'b0;
  endtask

  task automatic mon_one(int g);
    bit exp_rd, hs;
    int occ_nxt;
    logic [31:0] ea;
    logic [15:0] ed;
    if (rst) begin
      model_reset(g);
      return;
    end
    exp_rd = (st_m[g] == 1) && (occ_m[g] + infl_m[g] < DEPTH);
    chk("busy", g, busy_w[g], st_m[g] != 0);
    chk("mem_rd_en", g, rd_w[g], exp_rd);
    chk("svalid", g, sv_w[g], occ_m[g] != 0);
    if (stall_m[g]) begin
      chk("hold_svalid", g, sv_w[g], 1);
      chk("hold_sdata", g, sd_w[g], stall_sd[g]);
    end
    hs = sv_w[g] && rdy[g];
    if (hs) begin
      if (sbq[g].size() == 0) chk("scoreboard_nonempty", g, sbq[g].size(), 1);
      else begin
        ed = sbq[g].pop_front();
        chk("sdata", g, sd_w[g], ed);
      end
      chk("frame_done", g, fd_w[g], out_m[g] == fpix(g) - 1);
      if (fd_w[g]) fd_cnt[g]++;
      hs_cnt[g]++;
      out_m[g] = (out_m[g] == fpix(g) - 1) ? 0 : out_m[g] + 1;
    end else begin
      chk("frame_done_quiet", g, fd_w[g], 0);
    end
    if (rd_w[g]) begin
      ea = base_m[g] + 32'(idx_m[g] * 2);
      chk("mem_addr", g, addr_w[g], ea);
      sbq[g].push_back(memf(ea));
      rd_cnt[g]++;
      if (idx_m[g] == fpix(g) - 1) begin
        idx_m[g] = 0;
        base_m[g] = base[g];
      end else idx_m[g]++;
    end
    occ_nxt = occ_m[g] + infl_m[g] - (hs ? 1 : 0);
    chk("occupancy_bound", g, occ_nxt <= DEPTH, 1);
    case (st_m[g])
      0: if (en[g]) begin st_m[g] = 1; base_m[g] = base[g]; idx_m[g] = 0; end
      1: if (!en[g]) st_m[g] = 2;
      default: if (infl_m[g] == 0 && occ_m[g] == 0) begin
        st_m[g] = 0; idx_m[g] = 0; out_m[g] = 0;
      end
    endcase
    occ_m[g]    = occ_nxt;
    infl_m[g]   = rd_w[g] ? 1 : 0;
    stall_m[g]  = sv_w[g] && !rdy[g];
    stall_sd[g] = sd_w[g];
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) mon_one(g);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int g, int budget);
    for (int i = 0; i < budget && busy_w[g]; i++) step();
    chk("drain_to_idle", g, busy_w[g], 0);
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        busy;
    logic        rd;
    logic [31:0] addr;
    logic        sv;
    logic [15:0] sd;
  } vec_t;

  function automatic vec_t mk(logic e, logic r, logic b, logic d, logic [31:0] a, logic v, logic [15:0] s);
    vec_t t;
    t.en = e; t.rdy = r; t.busy = b; t.rd = d; t.addr = a; t.sv = v; t.sd = s;
    return t;
  endfunction

  initial begin
    vec_t tbl [9];
    int r0, r1, h0, h1, f0;

    tbl[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 16'h0);
    tbl[1] = mk(1'b1, 1'b1, 1'b1, 1'b1, A0,           1'b0, 16'h0);
    tbl[2] = mk(1'b1, 1'b1, 1'b1, 1'b1, A0 + 32'd2,   1'b0, 16'h0);
    tbl[3] = mk(1'b1, 1'b1, 1'b1, 1'b1, A0 + 32'd4,   1'b1, memf(A0));
    tbl[4] = mk(1'b0, 1'b1, 1'b1, 1'b1, A0 + 32'd6,   1'b1, memf(A0 + 32'd2));
    tbl[5] = mk(1'b0, 1'b1, 1'b1, 1'b0, A0 + 32'd8,   1'b1, memf(A0 + 32'd4));
    tbl[6] = mk(1'b0, 1'b1, 1'b1, 1'b0, A0 + 32'd8,   1'b1, memf(A0 + 32'd6));
    tbl[7] = mk(1'b0, 1'b1, 1'b1, 1'b0, A0 + 32'd8,   1'b0, 16'h0);
    tbl[8] = mk(1'b0, 1'b1, 1'b0, 1'b0, A0,           1'b0, 16'h0);

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      en[g] = 1'b0; rdy[g] = 1'b1; base[g] = 32'h0;
      rd_cnt[g] = 0; hs_cnt[g] = 0; fd_cnt[g] = 0;
      model_reset(g);
    end
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      chk("reset_busy", g, busy_w[g], 0);
      chk("reset_rd_en", g, rd_w[g], 0);
      chk("reset_addr", g, addr_w[g], 0);
      chk("reset_svalid", g, sv_w[g], 0);
      chk("reset_sdata", g, sd_w[g], 0);
      chk("reset_frame_done", g, fd_w[g], 0);
    end
    rst = 1'b0;

    // Start-up latency, address sequence and early disable
    for (int k = 0; k < 9; k++) begin
      en[0] = tbl[k].en; rdy[0] = tbl[k].rdy; base[0] = A0;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", k), 0, busy_w[0], tbl[k].busy);
      chk($sformatf("tbl%0d_rd_en", k), 0, rd_w[0], tbl[k].rd);
      chk($sformatf("tbl%0d_addr", k), 0, addr_w[0], tbl[k].addr);
      chk($sformatf("tbl%0d_svalid", k), 0, sv_w[0], tbl[k].sv);
      if (tbl[k].sv) chk($sformatf("tbl%0d_sdata", k), 0, sd_w[0], tbl[k].sd);
      step();
    end

    // Frame wrap with a base_addr change mid-frame
    base[0] = 32'h2000_0000; rdy[0] = 1'b1; f0 = fd_cnt[0]; en[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) base[0] = 32'h3000_0000;
      step();
    end
    en[0] = 1'b0;
    wait_idle(0, 20);
    chk("frame_done_pulses", 0, fd_cnt[0] - f0, 2);

    // Sink stall then release
    base[0] = 32'h5000_0000; rdy[0] = 1'b0; r0 = rd_cnt[0]; en[0] = 1'b1;
    repeat (12) step();
    chk("stall_reads", 0, rd_cnt[0] - r0, DEPTH);
    chk("stall_svalid", 0, sv_w[0], 1);
    h0 = hs_cnt[0]; rdy[0] = 1'b1;
    repeat (20) step();
    en[0] = 1'b0;
    wait_idle(0, 20);
    chk("stall_no_loss", 0, hs_cnt[0] - h0, rd_cnt[0] - r0);
    chk("stall_sb_drained", 0, sbq[0].size(), 0);

    // Disable at pixel 5 with the FIFO full, then restart
    base[0] = 32'h6000_0000; rdy[0] = 1'b0; r0 = rd_cnt[0]; en[0] = 1'b1;
    for (int i = 0; i < 20 && occ_m[0] != DEPTH; i++) step();
    chk("fill_reads", 0, rd_cnt[0] - r0, DEPTH);
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;
    repeat (3) step();
    chk("pixel5_reads", 0, rd_cnt[0] - r0, 5);
    en[0] = 1'b0; rdy[0] = 1'b1; r1 = rd_cnt[0]; h1 = hs_cnt[0];
    wait_idle(0, 20);
    chk("drain_no_reads", 0, rd_cnt[0] - r1, 0);
    chk("drain_delivered", 0, hs_cnt[0] - h1, 4);
    base[0] = 32'h4000_0000; en[0] = 1'b1;
    step();
    chk("restart_addr", 0, addr_w[0], 32'h4000_0000);
    chk("restart_rd_en", 0, rd_w[0], 1);
    en[0] = 1'b0;
    wait_idle(0, 20);

    // Reset while the FIFO holds three pixels
    base[0] = 32'h7000_0000; rdy[0] = 1'b0; en[0] = 1'b1;
    for (int i = 0; i < 20 && occ_m[0] != 3; i++) step();
    chk("three_held_svalid", 0, sv_w[0], 1);
    rst = 1'b1;
    step();
    chk("midreset_svalid", 0, sv_w[0], 0);
    chk("midreset_busy", 0, busy_w[0], 0);
    chk("midreset_rd_en", 0, rd_w[0], 0);
    chk("midreset_addr", 0, addr_w[0], 0);
    chk("midreset_sdata", 0, sd_w[0], 0);
    rst = 1'b0; base[0] = 32'h7100_0000; rdy[0] = 1'b1;
    for (int i = 0; i < 10 && !sv_w[0]; i++) step();
    chk("post_reset_first_pixel", 0, sd_w[0], memf(32'h7100_0000));
    repeat (10) step();
    en[0] = 1'b0;
    wait_idle(0, 20);

    // Random back-pressure over three 64-pixel frames
    base[1] = 32'h0800_0000; en[1] = 1'b1; h0 = hs_cnt[1]; f0 = fd_cnt[1];
    for (int i = 0; i < 2000 && hs_cnt[1] - h0 < 192; i++) begin
      rdy[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0)
        base[1] = 32'h0800_0000 + 32'($urandom_range(0, 15)) * 32'h100;
      step();
    end
    chk("random_progress", 1, hs_cnt[1] - h0 >= 192, 1);
    en[1] = 1'b0; rdy[1] = 1'b1;
    wait_idle(1, 30);
    chk("random_frame_done", 1, fd_cnt[1] - f0, 3);
    chk("random_sb_drained", 1, sbq[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
